gerenciador_alarme_sonoro: RTL and testbench

- Sequential stage directly downstream of the temperature control system; consumes its combinational alarm output (alarmeSonoroTemperatura).
- Debounces the alarm, latches it for the operator and drives a pulsating siren and a steady lamp.
- Escalates to a latched SCRAM request if the operator does not acknowledge in time.
- Counts confirmed alarm events for the control-room panel.

---
 rtl/gerenciador_alarme_sonoro_pkg.sv | 51 +++++
 rtl/gerenciador_alarme_sonoro_if.sv | 25 ++
 rtl/gerenciador_alarme_sonoro_contador_intervalo.sv | 35 +++
 rtl/gerenciador_alarme_sonoro.sv | 160 ++++++++++++++++
 tb/tb_gerenciador_alarme_sonoro.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/gerenciador_alarme_sonoro_pkg.sv
// Shared types and constants for the sound alarm manager: state codes,
// counter widths and the steady output pattern of each state.
package gerenciador_alarme_pkg;

  localparam int ESTADO_W = 3;
  localparam int CONT_W   = 8;
  localparam logic [CONT_W-1:0] CONT_SAT = 8'd255;

  localparam logic [ESTADO_W-1:0] EST_NORMAL      = 3'd0;
  localparam logic [ESTADO_W-1:0] EST_CONFIRMANDO = 3'd1;
  localparam logic [ESTADO_W-1:0] EST_ALARME      = 3'd2;
  localparam logic [ESTADO_W-1:0] EST_RECONHECIDO = 3'd3;
  localparam logic [ESTADO_W-1:0] EST_SCRAM       = 3'd4;

  typedef enum logic [ESTADO_W-1:0] {
    ST_NORMAL      = EST_NORMAL,
    ST_CONFIRMANDO = EST_CONFIRMANDO,
    ST_ALARME      = EST_ALARME,
    ST_RECONHECIDO = EST_RECONHECIDO,
    ST_SCRAM       = EST_SCRAM
  } estado_t;

  typedef struct packed {
    logic sirene;
    logic luz;
    logic ativo;
    logic scram;
  } saida_t;

  function automatic logic [CONT_W-1:0] inc_saturado(input logic [CONT_W-1:0] v);
    if (v == CONT_SAT) begin
      return v;
    end else begin
      return v + 8'd1;
    end
  endfunction

  // Output pattern on entry to a state; the ALARME siren then blinks from here.
  function automatic saida_t saida_fixa(input estado_t st);
    saida_t s;
    s = '0;
    case (st)
      ST_ALARME:      s = '{sirene: 1'b1, luz: 1'b1, ativo: 1'b1, scram: 1'b0};
      ST_RECONHECIDO: s = '{sirene: 1'b0, luz: 1'b1, ativo: 1'b1, scram: 1'b0};
      ST_SCRAM:       s = '{sirene: 1'b1, luz: 1'b1, ativo: 1'b1, scram: 1'b1};
      default:        s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/gerenciador_alarme_sonoro_if.sv
// Alarm/operator signal bundle between the temperature stage, the operator
// panel and the alarm manager.
interface gerenciador_alarme_sonoro_if
  import gerenciador_alarme_pkg::*;
;
  logic                alarme_temp_in;
  logic                ack_operador;
  logic                reset_scram;
  logic                sirene_out;
  logic                luz_alarme;
  logic                alarme_ativo;
  logic                scram_out;
  logic [ESTADO_W-1:0] estado;
  logic [CONT_W-1:0]   contagem_alarmes;

  modport master (
    output alarme_temp_in, ack_operador, reset_scram,
    input  sirene_out, luz_alarme, alarme_ativo, scram_out, estado, contagem_alarmes
  );

  modport slave (
    input  alarme_temp_in, ack_operador, reset_scram,
    output sirene_out, luz_alarme, alarme_ativo, scram_out, estado, contagem_alarmes
  );
endinterface

// File: rtl/gerenciador_alarme_sonoro_contador_intervalo.sv
// Interval counter: counts 0..LIMITE-1 while enabled, wraps after the
// terminal value, clear has priority over enable.
module contador_intervalo #(
  parameter int LIMITE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int W = $clog2(LIMITE + 1);
  localparam logic [W-1:0] TC_VAL = W'(LIMITE - 1);

  logic [W-1:0] cnt_r;

  // Count register with clear priority and wrap at the terminal value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en) begin
      if (cnt_r == TC_VAL) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + W'(1);
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign tc = (cnt_r == TC_VAL);
endmodule

// File: rtl/gerenciador_alarme_sonoro.sv
// Sound alarm manager: debounces the temperature alarm, latches it for the
// operator, drives siren/lamp, escalates to SCRAM and counts confirmed alarms.
module gerenciador_alarme_sonoro
  import gerenciador_alarme_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 4,
  parameter int BLINK_HALF   = 8,
  parameter int ACK_TIMEOUT  = 64,
  parameter int CLR_CYC      = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  gerenciador_alarme_sonoro_if.slave   bus
);

  estado_t           estado_r;
  saida_t            saida_r;
  logic [CONT_W-1:0] contagem_r;

  logic in_s, ack_s, rscram_s;
  logic deb_clr_s, deb_en_s, deb_tc_s;
  logic blink_clr_s, blink_en_s, blink_tc_s;
  logic to_clr_s, to_en_s, to_tc_s;
  logic limpa_clr_s, limpa_en_s, limpa_tc_s;

  assign in_s     = bus.alarme_temp_in;
  assign ack_s    = bus.ack_operador;
  assign rscram_s = bus.reset_scram;

  // Timer controls; each timer is held clear outside the state that uses it
  always_comb begin
    deb_clr_s   = 1'b1;
    deb_en_s    = 1'b0;
    blink_clr_s = 1'b1;
    blink_en_s  = 1'b0;
    to_clr_s    = 1'b1;
    to_en_s     = 1'b0;
    limpa_clr_s = 1'b1;
    limpa_en_s  = 1'b0;
    if (((estado_r == ST_NORMAL) || (estado_r == ST_CONFIRMANDO)) && in_s) begin
      deb_clr_s = 1'b0;
      deb_en_s  = 1'b1;
    end else begin
      deb_clr_s = 1'b1;
      deb_en_s  = 1'b0;
    end
    if (estado_r == ST_ALARME) begin
      blink_clr_s = 1'b0;
      blink_en_s  = 1'b1;
      to_clr_s    = 1'b0;
      to_en_s     = 1'b1;
    end else begin
      blink_clr_s = 1'b1;
      blink_en_s  = 1'b0;
      to_clr_s    = 1'b1;
      to_en_s     = 1'b0;
    end
    if ((estado_r == ST_RECONHECIDO) && !in_s) begin
      limpa_clr_s = 1'b0;
      limpa_en_s  = 1'b1;
    end else begin
      limpa_clr_s = 1'b1;
      limpa_en_s  = 1'b0;
    end
  end

  contador_intervalo #(.LIMITE(DEBOUNCE_CYC)) u_debounce (
    .clk(clk), .rst_n(rst_n), .clr(deb_clr_s), .en(deb_en_s), .tc(deb_tc_s)
  );
  contador_intervalo #(.LIMITE(BLINK_HALF)) u_pisca (
    .clk(clk), .rst_n(rst_n), .clr(blink_clr_s), .en(blink_en_s), .tc(blink_tc_s)
  );
  contador_intervalo #(.LIMITE(ACK_TIMEOUT)) u_timeout (
    .clk(clk), .rst_n(rst_n), .clr(to_clr_s), .en(to_en_s), .tc(to_tc_s)
  );
  contador_intervalo #(.LIMITE(CLR_CYC)) u_limpeza (
    .clk(clk), .rst_n(rst_n), .clr(limpa_clr_s), .en(limpa_en_s), .tc(limpa_tc_s)
  );

  // State machine; outputs are registered from the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_r   <= ST_NORMAL;
      saida_r    <= '0;
      contagem_r <= '0;
    end else begin
      case (estado_r)
        ST_NORMAL: begin
          if (in_s) begin
            estado_r <= ST_CONFIRMANDO;
          end else begin
            estado_r <= ST_NORMAL;
          end
          saida_r <= '0;
        end
        ST_CONFIRMANDO: begin
          if (!in_s) begin
            estado_r <= ST_NORMAL;
            saida_r  <= '0;
          end else if (deb_tc_s) begin
            estado_r   <= ST_ALARME;
            saida_r    <= saida_fixa(ST_ALARME);
            contagem_r <= inc_saturado(contagem_r);
          end else begin
            estado_r <= ST_CONFIRMANDO;
            saida_r  <= '0;
          end
        end
        ST_ALARME: begin
          // Acknowledge beats a coincident timeout
          if (ack_s && in_s) begin
            estado_r <= ST_RECONHECIDO;
            saida_r  <= saida_fixa(ST_RECONHECIDO);
          end else if (ack_s) begin
            estado_r <= ST_NORMAL;
            saida_r  <= '0;
          end else if (to_tc_s) begin
            estado_r <= ST_SCRAM;
            saida_r  <= saida_fixa(ST_SCRAM);
          end else if (blink_tc_s) begin
            estado_r       <= ST_ALARME;
            saida_r.sirene <= ~saida_r.sirene;
          end else begin
            estado_r <= ST_ALARME;
          end
        end
        ST_RECONHECIDO: begin
          if (!in_s && limpa_tc_s) begin
            estado_r <= ST_NORMAL;
            saida_r  <= '0;
          end else begin
            estado_r <= ST_RECONHECIDO;
            saida_r  <= saida_fixa(ST_RECONHECIDO);
          end
        end
        ST_SCRAM: begin
          if (rscram_s && !in_s) begin
            estado_r <= ST_NORMAL;
            saida_r  <= '0;
          end else begin
            estado_r <= ST_SCRAM;
            saida_r  <= saida_fixa(ST_SCRAM);
          end
        end
        default: begin
          estado_r <= ST_NORMAL;
          saida_r  <= '0;
        end
      endcase
    end
  end

  assign bus.sirene_out       = saida_r.sirene;
  assign bus.luz_alarme       = saida_r.luz;
  assign bus.alarme_ativo     = saida_r.ativo;
  assign bus.scram_out        = saida_r.scram;
  assign bus.estado           = estado_r;
  assign bus.contagem_alarmes = contagem_r;

endmodule

// File: tb/tb_gerenciador_alarme_sonoro.sv
// Directed self-checking bench for the sound alarm manager.
module tb_gerenciador_alarme_sonoro;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  gerenciador_alarme_sonoro_if bus();

  gerenciador_alarme_sonoro dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int est, input logic sir, input logic luz,
                         input logic atv, input logic scr);
    chk({tag, ".estado"}, 32'(bus.estado), 32'(est));
    chk({tag, ".sirene"}, 32'(bus.sirene_out), 32'(sir));
    chk({tag, ".luz"}, 32'(bus.luz_alarme), 32'(luz));
    chk({tag, ".ativo"}, 32'(bus.alarme_ativo), 32'(atv));
    chk({tag, ".scram"}, 32'(bus.scram_out), 32'(scr));
  endtask

  // One confirmed alarm acknowledged after the condition cleared: 5 cycles
  task automatic alarme_rapido();
    bus.alarme_temp_in = 1'b1;
    repeat (4) tick();
    bus.alarme_temp_in = 1'b0;
    bus.ack_operador   = 1'b1;
    tick();
    bus.ack_operador   = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    bus.alarme_temp_in = 1'b0;
    bus.ack_operador   = 1'b0;
    bus.reset_scram    = 1'b0;
    repeat (3) tick();
    chk_out("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset.cont", 32'(bus.contagem_alarmes), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle.estado", 32'(bus.estado), 32'd0);

    // Debounce reject
    bus.alarme_temp_in = 1'b1;
    tick();
    chk("deb.first", 32'(bus.estado), 32'd1);
    repeat (2) tick();
    chk_out("deb.third", 1, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.alarme_temp_in = 1'b0;
    tick();
    chk_out("deb.drop", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("deb.cont", 32'(bus.contagem_alarmes), 32'd0);

    // Confirm, blink, acknowledge, clear
    bus.alarme_temp_in = 1'b1;
    repeat (3) tick();
    chk("conf.e3", 32'(bus.estado), 32'd1);
    tick();
    chk_out("conf.e0", 2, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("conf.cont", 32'(bus.contagem_alarmes), 32'd1);
    repeat (7) tick();
    chk("blink.e7", 32'(bus.sirene_out), 32'd1);
    tick();
    chk("blink.e8", 32'(bus.sirene_out), 32'd0);
    repeat (7) tick();
    chk("blink.e15", 32'(bus.sirene_out), 32'd0);
    tick();
    chk("blink.e16", 32'(bus.sirene_out), 32'd1);
    repeat (3) tick();
    chk("ack.e19", 32'(bus.estado), 32'd2);
    bus.ack_operador = 1'b1;
    tick();
    chk_out("ack.e20", 3, 1'b0, 1'b1, 1'b1, 1'b0);
    bus.ack_operador   = 1'b0;
    bus.alarme_temp_in = 1'b0;
    repeat (3) tick();
    chk("clr.low3", 32'(bus.estado), 32'd3);
    bus.alarme_temp_in = 1'b1;
    tick();
    chk("clr.blip", 32'(bus.estado), 32'd3);
    bus.alarme_temp_in = 1'b0;
    repeat (3) tick();
    chk("clr.restart3", 32'(bus.estado), 32'd3);
    tick();
    chk_out("clr.done", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("clr.cont", 32'(bus.contagem_alarmes), 32'd1);

    // Timeout escalation with the condition dropped while latched
    bus.alarme_temp_in = 1'b1;
    repeat (4) tick();
    chk("to.e0", 32'(bus.estado), 32'd2);
    chk("to.cont", 32'(bus.contagem_alarmes), 32'd2);
    bus.alarme_temp_in = 1'b0;
    repeat (63) tick();
    chk_out("to.e63", 2, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    chk_out("to.e64", 4, 1'b1, 1'b1, 1'b1, 1'b1);
    bus.alarme_temp_in = 1'b1;
    bus.reset_scram    = 1'b1;
    tick();
    chk("scram.rs_in1", 32'(bus.estado), 32'd4);
    bus.alarme_temp_in = 1'b0;
    bus.reset_scram    = 1'b0;
    bus.ack_operador   = 1'b1;
    tick();
    chk("scram.ack", 32'(bus.estado), 32'd4);
    bus.ack_operador = 1'b0;
    bus.reset_scram  = 1'b1;
    tick();
    chk_out("scram.exit", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.reset_scram = 1'b0;

    // Ack and timeout on the same cycle
    bus.alarme_temp_in = 1'b1;
    repeat (4) tick();
    chk("col.cont", 32'(bus.contagem_alarmes), 32'd3);
    for (int i = 1; i <= 63; i++) begin
      tick();
      chk("col.noscram", 32'(bus.scram_out), 32'd0);
    end
    chk("col.e63", 32'(bus.estado), 32'd2);
    bus.ack_operador = 1'b1;
    tick();
    chk_out("col.e64", 3, 1'b0, 1'b1, 1'b1, 1'b0);
    bus.ack_operador   = 1'b0;
    bus.alarme_temp_in = 1'b0;
    repeat (4) tick();
    chk("col.clear", 32'(bus.estado), 32'd0);

    // Ack after the condition cleared goes straight to NORMAL
    bus.alarme_temp_in = 1'b1;
    repeat (4) tick();
    bus.alarme_temp_in = 1'b0;
    tick();
    chk("late.latched", 32'(bus.estado), 32'd2);
    bus.ack_operador = 1'b1;
    tick();
    chk_out("late.ack", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("late.cont", 32'(bus.contagem_alarmes), 32'd4);
    bus.ack_operador = 1'b0;

    // Saturation of the event counter
    repeat (250) alarme_rapido();
    chk("sat.254", 32'(bus.contagem_alarmes), 32'd254);
    alarme_rapido();
    chk("sat.255", 32'(bus.contagem_alarmes), 32'd255);
    repeat (49) alarme_rapido();
    chk("sat.hold", 32'(bus.contagem_alarmes), 32'd255);
    chk("sat.estado", 32'(bus.estado), 32'd0);

    // Asynchronous reset while in SCRAM
    bus.alarme_temp_in = 1'b1;
    repeat (4) tick();
    bus.alarme_temp_in = 1'b0;
    repeat (64) tick();
    chk("ar.scram", 32'(bus.estado), 32'd4);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("ar.async", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ar.cont", 32'(bus.contagem_alarmes), 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    chk_out("ar.release", 0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
